// File: rtl/mac_operand_feeder.sv
// Sequences one MAC unit through a VEC_LEN-long dot product. It pops paired
// operands, clears the MAC, streams the pairs with En pacing and captures Cout.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; result held
// S_CLEAR | one cycle with mac_clr high
// S_STREAM| popping A/B pairs together, one mac_en per pop
// S_DRAIN | waiting out the MAC pipeline, then capture mac_cout
module mac_operand_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LEN    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  input  logic                    a_valid,
  input  logic [DATA_WIDTH-1:0]   a_data,
  output logic                    a_ready,
  input  logic                    b_valid,
  input  logic [DATA_WIDTH-1:0]   b_data,
  output logic                    b_ready,
  output logic                    mac_en,
  output logic                    mac_clr,
  output logic [DATA_WIDTH-1:0]   mac_a,
  output logic [DATA_WIDTH-1:0]   mac_b,
  input  logic [3*DATA_WIDTH-1:0] mac_cout,
  output logic [3*DATA_WIDTH-1:0] result,
  output logic                    result_valid
);

  localparam int RES_W = 3 * DATA_WIDTH;
  localparam int CNT_W = $clog2(VEC_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'(VEC_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        pair_cnt_q, pair_cnt_d;
  logic [1:0]              drain_cnt_q, drain_cnt_d;
  logic                    mac_en_q, mac_en_d;
  logic                    mac_clr_q, mac_clr_d;
  logic [DATA_WIDTH-1:0]   mac_a_q, mac_a_d;
  logic [DATA_WIDTH-1:0]   mac_b_q, mac_b_d;
  logic [RES_W-1:0]        result_q, result_d;
  logic                    result_valid_q, result_valid_d;
  logic                    pop;

  // A and B are only ever consumed as a pair.
  assign pop = (state_q == S_STREAM) && a_valid && b_valid;

  always_comb begin
    state_d        = state_q;
    pair_cnt_d     = pair_cnt_q;
    drain_cnt_d    = drain_cnt_q;
    mac_en_d       = 1'b0;
    mac_clr_d      = 1'b0;
    mac_a_d        = mac_a_q;
    mac_b_d        = mac_b_q;
    result_d       = result_q;
    result_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_CLEAR;
          mac_clr_d = 1'b1;
        end
      end
      S_CLEAR: begin
        state_d    = S_STREAM;
        pair_cnt_d = '0;
      end
      S_STREAM: begin
        if (pop) begin
          mac_en_d   = 1'b1;
          mac_a_d    = a_data;
          mac_b_d    = b_data;
          pair_cnt_d = pair_cnt_q + 1'b1;
          if (pair_cnt_q == LAST_PAIR) begin
            state_d     = S_DRAIN;
            drain_cnt_d = '0;
          end
        end
      end
      S_DRAIN: begin
        // Two MAC pipeline stages plus one cycle for Cout to settle.
        if (drain_cnt_q == 2'd2) begin
          result_d       = mac_cout;
          result_valid_d = 1'b1;
          state_d        = S_IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      pair_cnt_q     <= '0;
      drain_cnt_q    <= '0;
      mac_en_q       <= 1'b0;
      mac_clr_q      <= 1'b0;
      mac_a_q        <= '0;
      mac_b_q        <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pair_cnt_q     <= pair_cnt_d;
      drain_cnt_q    <= drain_cnt_d;
      mac_en_q       <= mac_en_d;
      mac_clr_q      <= mac_clr_d;
      mac_a_q        <= mac_a_d;
      mac_b_q        <= mac_b_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign a_ready      = pop;
  assign b_ready      = pop;
  assign busy         = (state_q != S_IDLE);
  assign done         = result_valid_q;
  assign result_valid = result_valid_q;
  assign result       = result_q;
  assign mac_en       = mac_en_q;
  assign mac_clr      = mac_clr_q;
  assign mac_a        = mac_a_q;
  assign mac_b        = mac_b_q;

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Bench for mac_operand_feeder: operand FIFO model, two-stage MAC model,
// a four-pair and an eight-pair instance, directed vectors plus corner sequences.
module tb_mac_operand_feeder;

  localparam int DW = 8;
  localparam int RW = 3 * DW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          start4, start8;
  logic          a_valid, b_valid;
  logic [DW-1:0] a_data, b_data;

  logic          busy4, done4, a_ready4, b_ready4, mac_en4, mac_clr4, rv4;
  logic [DW-1:0] mac_a4, mac_b4;
  logic [RW-1:0] mac_cout4, result4;
  logic          busy8, done8, a_ready8, b_ready8, mac_en8, mac_clr8, rv8;
  logic [DW-1:0] mac_a8, mac_b8;
  logic [RW-1:0] mac_cout8, result8;

  mac_operand_feeder #(.DATA_WIDTH(DW), .VEC_LEN(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .busy(busy4), .done(done4),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready4),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready4),
    .mac_en(mac_en4), .mac_clr(mac_clr4), .mac_a(mac_a4), .mac_b(mac_b4),
    .mac_cout(mac_cout4), .result(result4), .result_valid(rv4)
  );

  mac_operand_feeder #(.DATA_WIDTH(DW), .VEC_LEN(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .busy(busy8), .done(done8),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready8),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready8),
    .mac_en(mac_en8), .mac_clr(mac_clr8), .mac_a(mac_a8), .mac_b(mac_b8),
    .mac_cout(mac_cout8), .result(result8), .result_valid(rv8)
  );

  // Operand FIFOs shared by both instances; only one is ever started at a time.
  logic [DW-1:0] a_mem [16];
  logic [DW-1:0] b_mem [16];
  logic [3:0]    a_ptr, b_ptr;
  logic [4:0]    fifo_len;
  logic          fifo_clr, a_stall, b_stall;
  logic          a_ready_any, b_ready_any;

  assign a_ready_any = a_ready4 | a_ready8;
  assign b_ready_any = b_ready4 | b_ready8;
  assign a_valid = ({1'b0, a_ptr} < fifo_len) && !a_stall;
  assign b_valid = ({1'b0, b_ptr} < fifo_len) && !b_stall;
  assign a_data  = a_mem[a_ptr];
  assign b_data  = b_mem[b_ptr];

  always @(posedge clk) begin
    if (fifo_clr) begin
      a_ptr <= '0;
      b_ptr <= '0;
    end else begin
      if (a_ready_any && a_valid) a_ptr <= a_ptr + 1'b1;
      if (b_ready_any && b_valid) b_ptr <= b_ptr + 1'b1;
    end
  end

  // MAC models: product register, delayed enable, accumulator.
  logic [RW-1:0] prod4, acc4, prod8, acc8;
  logic          en4_d, en8_d;

  always @(posedge clk) begin
    if (rst) begin
      prod4 <= '0; acc4 <= '0; en4_d <= 1'b0;
      prod8 <= '0; acc8 <= '0; en8_d <= 1'b0;
    end else begin
      prod4 <= RW'(mac_a4) * RW'(mac_b4);
      en4_d <= mac_en4;
      if (mac_clr4) acc4 <= '0;
      else if (en4_d) acc4 <= acc4 + prod4;
      prod8 <= RW'(mac_a8) * RW'(mac_b8);
      en8_d <= mac_en8;
      if (mac_clr8) acc8 <= '0;
      else if (en8_d) acc8 <= acc8 + prod8;
    end
  end
  assign mac_cout4 = acc4;
  assign mac_cout8 = acc8;

  // Monitor on the falling edge.
  logic          sel8;
  int            cyc = 0, pop_cnt = 0, done_cnt = 0, clr_cnt = 0;
  int            onesided = 0, overlap = 0, last_pop_cyc = 0, gap_snap = 0;
  logic [31:0]   en_hist = '0, clr_hist = '0, en_snap = '0, clr_snap = '0;
  logic [RW-1:0] res_snap = '0;
  logic          busy_snap = 1'b0, rv_snap = 1'b0;

  always @(negedge clk) begin
    logic en_any, clr_any;
    en_any  = mac_en4 | mac_en8;
    clr_any = mac_clr4 | mac_clr8;
    cyc = cyc + 1;
    if (a_ready_any != b_ready_any) onesided = onesided + 1;
    if (a_ready_any && !(a_valid && b_valid)) onesided = onesided + 1;
    if (a_ready_any) begin
      pop_cnt = pop_cnt + 1;
      last_pop_cyc = cyc;
    end
    if (en_any && clr_any) overlap = overlap + 1;
    if (clr_any) clr_cnt = clr_cnt + 1;
    en_hist  = {en_hist[30:0], en_any};
    clr_hist = {clr_hist[30:0], clr_any};
    if (done4 | done8) begin
      done_cnt  = done_cnt + 1;
      en_snap   = en_hist;
      clr_snap  = clr_hist;
      gap_snap  = cyc - last_pop_cyc;
      res_snap  = sel8 ? result8 : result4;
      busy_snap = busy4 | busy8;
      rv_snap   = rv4 | rv8;
    end
  end

  int n_checks = 0, n_fail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic load_fifo(input logic [15:0][DW-1:0] a, input logic [15:0][DW-1:0] b,
                           input int n);
    for (int i = 0; i < 16; i++) begin
      a_mem[i] = a[i];
      b_mem[i] = b[i];
    end
    fifo_len = 5'(n);
    @(posedge clk); #1 fifo_clr = 1'b1;
    @(posedge clk); #1 fifo_clr = 1'b0;
  endtask

  task automatic pulse_start(input bit use8);
    @(posedge clk); #1;
    if (use8) start8 = 1'b1; else start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    start8 = 1'b0;
  endtask

  // Leaves the caller at the falling edge of the done cycle.
  task automatic wait_done(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done4 | done8) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, " done_seen"}, longint'(ok), 1);
  endtask

  task automatic wait_pops(input int base, input int n);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (pop_cnt - base >= n) begin
        ok = 1'b1;
        break;
      end
    end
    check("pop_wait", longint'(ok), 1);
  endtask

  typedef struct {
    string                name;
    bit                   use8;
    int                   len;
    logic [15:0][DW-1:0]  a;
    logic [15:0][DW-1:0]  b;
    longint               exp;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int pb, db, cb, ob, vb;
    longint win;

    vecs[0] = '{"basic",     1'b0, 4, 128'h04030201, 128'h08070605, 70};
    vecs[1] = '{"twos",      1'b0, 4, 128'h02020202, 128'h03030303, 24};
    vecs[2] = '{"edge4",     1'b0, 4, 128'h01FF00FF, 128'hFF0109FF, 65535};
    vecs[3] = '{"fullscale", 1'b1, 8, 128'hFFFFFFFF_FFFFFFFF, 128'hFFFFFFFF_FFFFFFFF, 520200};
    vecs[4] = '{"ramp8",     1'b1, 8, 128'h08070605_04030201, 128'h08070605_04030201, 204};

    rst = 1'b1; start4 = 1'b0; start8 = 1'b0; sel8 = 1'b0;
    fifo_clr = 1'b1; fifo_len = '0; a_stall = 1'b0; b_stall = 1'b0;
    for (int i = 0; i < 16; i++) begin a_mem[i] = '0; b_mem[i] = '0; end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; fifo_clr = 1'b0;

    check("rst busy",    longint'(busy4 | busy8), 0);
    check("rst done",    longint'(done4 | done8 | rv4 | rv8), 0);
    check("rst mac_en",  longint'(mac_en4 | mac_en8), 0);
    check("rst mac_clr", longint'(mac_clr4 | mac_clr8), 0);
    check("rst mac_a",   longint'(mac_a4 | mac_a8), 0);
    check("rst mac_b",   longint'(mac_b4 | mac_b8), 0);
    check("rst result",  longint'(result4 | result8), 0);

    for (int v = 0; v < 5; v++) begin
      sel8 = vecs[v].use8;
      load_fifo(vecs[v].a, vecs[v].b, vecs[v].len);
      pb = pop_cnt; db = done_cnt; cb = clr_cnt; ob = onesided; vb = overlap;
      pulse_start(vecs[v].use8);
      wait_done(vecs[v].name, 200);
      #1;
      win = (longint'(1) << (vecs[v].len + 6)) - 1;
      check({vecs[v].name, " result"}, longint'(res_snap), vecs[v].exp);
      check({vecs[v].name, " result_valid"}, longint'(rv_snap), 1);
      check({vecs[v].name, " busy_at_done"}, longint'(busy_snap), 0);
      check({vecs[v].name, " pop_to_done"}, longint'(gap_snap), 4);
      check({vecs[v].name, " en_pattern"}, longint'(en_snap) & win,
            ((longint'(1) << vecs[v].len) - 1) << 3);
      check({vecs[v].name, " clr_pattern"}, longint'(clr_snap) & win,
            longint'(1) << (vecs[v].len + 4));
      repeat (4) @(posedge clk);
      check({vecs[v].name, " pops"}, longint'(pop_cnt - pb), vecs[v].len);
      check({vecs[v].name, " dones"}, longint'(done_cnt - db), 1);
      check({vecs[v].name, " clr_cycles"}, longint'(clr_cnt - cb), 1);
      check({vecs[v].name, " onesided"}, longint'(onesided - ob), 0);
      check({vecs[v].name, " en_clr_overlap"}, longint'(overlap - vb), 0);
    end

    // Stalls: B low for two cycles after pair 2, A low for one after pair 3.
    sel8 = 1'b0;
    load_fifo(128'h04030201, 128'h08070605, 4);
    pb = pop_cnt; ob = onesided;
    pulse_start(1'b0);
    wait_pops(pb, 2);
    @(posedge clk); #1 b_stall = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 b_stall = 1'b0;
    wait_pops(pb, 3);
    @(posedge clk); #1 a_stall = 1'b1;
    @(posedge clk); #1 a_stall = 1'b0;
    wait_done("stall", 200);
    #1;
    check("stall result", longint'(res_snap), 70);
    check("stall en_pattern", longint'(en_snap) & 32'h7FFF, 32'h328);
    check("stall clr_pattern", longint'(clr_snap) & 32'h7FFF, 32'h800);
    check("stall pop_to_done", longint'(gap_snap), 4);
    check("stall pops", longint'(pop_cnt - pb), 4);
    check("stall onesided", longint'(onesided - ob), 0);

    // Back-to-back: second start issued in the done cycle.
    load_fifo(128'h02020202_04030201, 128'h03030303_08070605, 8);
    pb = pop_cnt; db = done_cnt; cb = clr_cnt;
    pulse_start(1'b0);
    wait_done("b2b first", 200);
    start4 = 1'b1;
    #1;
    check("b2b first result", longint'(res_snap), 70);
    @(posedge clk); #1 start4 = 1'b0;
    check("b2b clr_follows_done", longint'(mac_clr4), 1);
    wait_done("b2b second", 200);
    #1;
    check("b2b second result", longint'(res_snap), 24);
    check("b2b second en_pattern", longint'(en_snap) & 32'h3FF, 32'h78);
    repeat (4) @(posedge clk);
    check("b2b pops", longint'(pop_cnt - pb), 8);
    check("b2b dones", longint'(done_cnt - db), 2);
    check("b2b clr_cycles", longint'(clr_cnt - cb), 2);

    // Start during STREAM must be ignored.
    load_fifo(128'h04030201_04030201, 128'h08070605_08070605, 8);
    pb = pop_cnt; db = done_cnt; cb = clr_cnt;
    pulse_start(1'b0);
    wait_pops(pb, 1);
    pulse_start(1'b0);
    wait_done("busystart", 200);
    #1;
    check("busystart result", longint'(res_snap), 70);
    repeat (12) @(posedge clk);
    check("busystart pops", longint'(pop_cnt - pb), 4);
    check("busystart dones", longint'(done_cnt - db), 1);
    check("busystart clr_cycles", longint'(clr_cnt - cb), 1);

    // Reset after two pops abandons the operation.
    load_fifo(128'h04030201, 128'h08070605, 4);
    pb = pop_cnt; db = done_cnt;
    pulse_start(1'b0);
    wait_pops(pb, 2);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("midrst busy",    longint'(busy4), 0);
    check("midrst done",    longint'(done4 | rv4), 0);
    check("midrst mac_en",  longint'(mac_en4), 0);
    check("midrst mac_clr", longint'(mac_clr4), 0);
    check("midrst mac_a",   longint'(mac_a4), 0);
    check("midrst mac_b",   longint'(mac_b4), 0);
    check("midrst result",  longint'(result4), 0);
    check("midrst a_ready", longint'(a_ready4 | b_ready4), 0);
    repeat (20) @(posedge clk);
    check("midrst no_done", longint'(done_cnt - db), 0);
    load_fifo(128'h01010101, 128'h01020304, 4);
    pulse_start(1'b0);
    wait_done("postrst", 200);
    #1;
    check("postrst result", longint'(res_snap), 10);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, failures so far %0d", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
